game_time_display: RTL and testbench

Converts the 10-bit tenth-second count produced by the game clock counter into four BCD digits and drives four 7-segment digit patterns for the game timer readout. It sits directly downstream of the game clock counter. Its count input connects straight to that counter's output, and its segment outputs go to the board display header. Conversion is a sequential shift-and-add-3 (double-dabble) engine, and the outputs are held glitch-free between updates.

---
 rtl/game_display_pkg.sv | 47 ++++
 rtl/seg7_encode.sv | 14 +
 rtl/game_time_display.sv | 143 ++++++++++++++
 tb/tb_game_time_display.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/game_display_pkg.sv
// Shared types and constants for the game timer readout: FSM states,
// active-high 7-segment glyphs (bit0 = a ... bit6 = g) and the encoder helper.
package game_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [3:0] ADD3_THRESH = 4'd5;

  // Nibble plus blank flag to segment pattern; non-decimal nibbles show blank.
  function automatic logic [6:0] seg_pattern(input logic [3:0] nib,
                                             input logic       blank,
                                             input logic       active_low);
    logic [6:0] pat;
    case (nib)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_BLANK;
    endcase
    if (blank) pat = SEG_BLANK;
    return active_low ? ~pat : pat;
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational BCD nibble to 7-segment encoder with blanking and polarity select.
module seg7_encode
  import game_display_pkg::*;
#(
  parameter int unsigned SEG_ACTIVE_LOW = 1
) (
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg_c
);

  assign seg_c = seg_pattern(bcd, blank, SEG_ACTIVE_LOW != 0);

endmodule

// File: rtl/game_time_display.sv
// Game timer readout: double-dabble conversion of the tenth-second count into
// BCD digits, with registered BCD and 7-segment outputs updated atomically.
module game_time_display
  import game_display_pkg::*;
#(
  parameter int unsigned COUNT_W        = 10,
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned BLANK_LEADING  = 1,
  parameter int unsigned SEG_ACTIVE_LOW = 1
) (
  input  logic                  CLOCK10M,
  input  logic                  RESET_N,
  input  logic [COUNT_W-1:0]    count_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [7*DIGITS-1:0]   hex_out,
  output logic                  busy,
  output logic                  update
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned SEG_W = 7 * DIGITS;
  localparam int unsigned CNT_W = $clog2(COUNT_W + 1);

  // Display pattern for a count of zero, used as the reset value of hex_out.
  function automatic logic [SEG_W-1:0] hex_reset_f();
    logic [SEG_W-1:0] v;
    v = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      v[7*k +: 7] = seg_pattern(4'd0, (k != 0) && (BLANK_LEADING != 0),
                                SEG_ACTIVE_LOW != 0);
    end
    return v;
  endfunction

  localparam logic [SEG_W-1:0] HEX_RESET = hex_reset_f();

  state_t             state_q, state_d;
  logic [COUNT_W-1:0] last_q, last_d;
  logic [COUNT_W-1:0] shift_q, shift_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [CNT_W-1:0]   iter_q, iter_d;
  logic [BCD_W-1:0]   bcd_d;
  logic [SEG_W-1:0]   hex_d;
  logic               busy_d;
  logic               update_d;

  logic [BCD_W-1:0]   scratch_adj_c;
  logic [DIGITS-1:0]  blank_c;
  logic [SEG_W-1:0]   hex_c;
  logic               lead_zero;

  // Add-3 correction on every nibble that would overflow past 9 when doubled.
  always_comb begin
    scratch_adj_c = scratch_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= ADD3_THRESH) begin
        scratch_adj_c[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Leading-zero blanking, scanned from the most significant digit down.
  always_comb begin
    lead_zero = (BLANK_LEADING != 0);
    blank_c   = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      lead_zero  = lead_zero && (scratch_q[4*i +: 4] == 4'd0);
      blank_c[i] = lead_zero && (i != 0);
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_enc
    seg7_encode #(
      .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
    ) u_enc (
      .bcd   (scratch_q[4*g +: 4]),
      .blank (blank_c[g]),
      .seg_c (hex_c[7*g +: 7])
    );
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    iter_d    = iter_q;
    bcd_d     = bcd_out;
    hex_d     = hex_out;
    busy_d    = (state_q != IDLE);
    update_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_in != last_q) begin
          last_d    = count_in;
          shift_d   = count_in;
          scratch_d = '0;
          iter_d    = CNT_W'(COUNT_W);
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        {scratch_d, shift_d} = {scratch_adj_c, shift_q} << 1;
        iter_d               = iter_q - CNT_W'(1);
        if (iter_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        bcd_d    = scratch_q;
        hex_d    = hex_c;
        update_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK10M or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      last_q    <= '0;
      shift_q   <= '0;
      scratch_q <= '0;
      iter_q    <= '0;
      bcd_out   <= '0;
      hex_out   <= HEX_RESET;
      busy      <= 1'b0;
      update    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      iter_q    <= iter_d;
      bcd_out   <= bcd_d;
      hex_out   <= hex_d;
      busy      <= busy_d;
      update    <= update_d;
    end
  end

endmodule

// File: tb/tb_game_time_display.sv
// Directed bench for game_time_display: default instance plus a
// BLANK_LEADING=0 instance, checked with immediate assertions.
module tb_game_time_display;

  localparam logic [6:0] L0 = 7'b1000000;
  localparam logic [6:0] L1 = 7'b1111001;
  localparam logic [6:0] L2 = 7'b0100100;
  localparam logic [6:0] L3 = 7'b0110000;
  localparam logic [6:0] L5 = 7'b0010010;
  localparam logic [6:0] L7 = 7'b1111000;
  localparam logic [6:0] LB = 7'b1111111;

  logic        clk;
  logic        rst_n;
  logic [9:0]  count_in;
  logic [15:0] bcd_out;
  logic [27:0] hex_out;
  logic        busy;
  logic        update;
  logic [9:0]  count_nb;
  logic [15:0] bcd_nb;
  logic [27:0] hex_nb;
  logic        busy_nb;
  logic        update_nb;

  int checks = 0;
  int errors = 0;
  int upd_cnt = 0;
  int busy_cnt = 0;
  int cyc;
  int u0;
  logic b1;

  game_time_display dut (
    .CLOCK10M (clk),
    .RESET_N  (rst_n),
    .count_in (count_in),
    .bcd_out  (bcd_out),
    .hex_out  (hex_out),
    .busy     (busy),
    .update   (update)
  );

  game_time_display #(
    .BLANK_LEADING(0)
  ) dut_nb (
    .CLOCK10M (clk),
    .RESET_N  (rst_n),
    .count_in (count_nb),
    .bcd_out  (bcd_nb),
    .hex_out  (hex_nb),
    .busy     (busy_nb),
    .update   (update_nb)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  always @(negedge clk) begin
    if (update === 1'b1) upd_cnt++;
    if (busy === 1'b1) busy_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for an update pulse; with skip set, the first edge is the sample edge
  // and cyc counts edges after it. busy one edge after the sample goes to b1.
  task automatic wait_upd(input bit nb, input bit skip, output int cyc_o, output logic b1_o);
    cyc_o = 0;
    b1_o  = 1'b0;
    if (skip) @(posedge clk);
    while (cyc_o < 40) begin
      @(posedge clk);
      #1;
      cyc_o++;
      if (cyc_o == 1) b1_o = nb ? busy_nb : busy;
      if ((nb ? update_nb : update) === 1'b1) break;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    count_in = '0;
    count_nb = '0;
    repeat (20) @(posedge clk);
    #1;
    chk("rst_bcd", 64'(bcd_out), 64'h0);
    chk("rst_hex", 64'(hex_out), 64'({LB, LB, LB, L0}));
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_update", 64'(update), 64'h0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_bcd", 64'(bcd_out), 64'h0);
    chk("idle_hex", 64'(hex_out), 64'({LB, LB, LB, L0}));
    chk("idle_busy_seen", 64'(busy_cnt), 64'h0);
    chk("idle_upd_seen", 64'(upd_cnt), 64'h0);
    chk("nb_rst_hex", 64'(hex_nb), 64'({L0, L0, L0, L0}));

    // 0 -> 123: latency and single pulse
    u0 = upd_cnt;
    count_in = 10'd123;
    wait_upd(1'b0, 1'b1, cyc, b1);
    chk("lat_123", 64'(cyc), 64'd11);
    chk("busy_rise_123", 64'(b1), 64'h1);
    chk("bcd_123", 64'(bcd_out), 64'h0123);
    chk("hex_123", 64'(hex_out), 64'({LB, L1, L2, L3}));
    @(posedge clk);
    #1;
    chk("busy_fall_123", 64'(busy), 64'h0);
    repeat (4) @(posedge clk);
    #1;
    chk("pulses_123", 64'(upd_cnt - u0), 64'd1);

    // 1023: all digits lit
    count_in = 10'd1023;
    wait_upd(1'b0, 1'b1, cyc, b1);
    chk("lat_1023", 64'(cyc), 64'd11);
    chk("bcd_1023", 64'(bcd_out), 64'h1023);
    chk("hex_1023", 64'(hex_out), 64'({L1, L0, L2, L3}));

    // Wrap to 0
    count_in = 10'd0;
    wait_upd(1'b0, 1'b1, cyc, b1);
    chk("bcd_wrap", 64'(bcd_out), 64'h0);
    chk("hex_wrap", 64'(hex_out), 64'({LB, LB, LB, L0}));

    // 500 then 501 three cycles into the conversion
    count_in = 10'd500;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    count_in = 10'd501;
    wait_upd(1'b0, 1'b0, cyc, b1);
    chk("bcd_500", 64'(bcd_out), 64'h0500);
    chk("hex_500", 64'(hex_out), 64'({LB, L5, L0, L0}));
    wait_upd(1'b0, 1'b1, cyc, b1);
    chk("lat_501", 64'(cyc), 64'd11);
    chk("bcd_501", 64'(bcd_out), 64'h0501);

    // Reset during conversion of 777
    count_in = 10'd777;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    u0 = upd_cnt;
    rst_n = 1'b0;
    #1;
    chk("midrst_bcd", 64'(bcd_out), 64'h0);
    chk("midrst_hex", 64'(hex_out), 64'({LB, LB, LB, L0}));
    chk("midrst_busy", 64'(busy), 64'h0);
    chk("midrst_update", 64'(update), 64'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_pulse", 64'(upd_cnt - u0), 64'd0);
    rst_n = 1'b1;
    wait_upd(1'b0, 1'b1, cyc, b1);
    chk("lat_777", 64'(cyc), 64'd11);
    chk("bcd_777", 64'(bcd_out), 64'h0777);
    chk("hex_777", 64'(hex_out), 64'({LB, L7, L7, L7}));

    // No leading-zero blanking
    count_nb = 10'd5;
    wait_upd(1'b1, 1'b1, cyc, b1);
    chk("nb_lat_5", 64'(cyc), 64'd11);
    chk("nb_bcd_5", 64'(bcd_nb), 64'h0005);
    chk("nb_hex_5", 64'(hex_nb), 64'({L0, L0, L0, L5}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
